clk_sched: RTL and testbench
============================

CLK_SCHED -- requirements
Module: clk_sched

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels (2..8).
REQ-002 Parameter LEN, default 25: width of each channel's step value and counter.
REQ-003 Parameter DEF_STEP, default 25000000: half-period step loaded into every channel at reset.
REQ-004 clk  input  1  master clock; all state is updated on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 cfg_valid  input  1  a configuration command is present.
REQ-007 cfg_ready  output  1  the block accepts the command this cycle.
REQ-008 cfg_ch  input  clog2(NCH)  target channel index.
REQ-009 cfg_en  input  1  1 = run at cfg_step; 0 = stop the channel.
REQ-010 cfg_step  input  LEN  requested half-period in clk cycles.
REQ-011 tick  output  NCH  one-cycle pulse per channel at each half-period boundary.
REQ-012 clkout  output  NCH  divided square wave per channel; period = 2*step cycles.
REQ-013 active  output  NCH  channel state is not IDLE.

Function
REQ-014 A command transfers only on a rising clk edge where cfg_valid=1 and cfg_ready=1.
REQ-015 cfg_ready = 0 when channel cfg_ch is in PEND, else 1; it depends combinationally on cfg_ch, not on cfg_valid.
REQ-016 Each channel runs FSM IDLE/RUN/PEND; state = IDLE holds ctr=0, clkout=1, tick=0.
REQ-017 IDLE + accepted cfg_en=1 -> RUN: step <= cfg_step, ctr <= 0; first tick occurs step cycles after the accept edge.
REQ-018 IDLE + accepted cfg_en=0 -> stays IDLE; no output change.
REQ-019 RUN: ctr increments each cycle; when ctr == step-1: tick=1 for that cycle, clkout toggles on the next edge, ctr <= 0.
REQ-020 RUN + accepted cfg_en=1 -> PEND: cfg_step is stored in a shadow register; the live step is unchanged.
REQ-021 PEND: counting continues with the old step; at the next boundary, step <= shadow, ctr <= 0, -> RUN; no partial period is produced.
REQ-022 An accept in the same cycle as a RUN boundary completes the current period with the old step, and the shadow applies at the following boundary.
REQ-023 RUN + accepted cfg_en=0 -> IDLE on the next edge: ctr=0, clkout=1, and the tick for that cycle is suppressed.
REQ-024 cfg_step = 0 is treated as 1, so clkout toggles every cycle and tick is held high.
REQ-025 Channels are fully independent; a command affects only channel cfg_ch.
REQ-026 The counter compares with unsigned LEN-bit arithmetic; ctr never exceeds step-1 and never wraps.
REQ-027 An out-of-range cfg_ch (>= NCH) is accepted with cfg_ready=1 and ignored.

Reset
REQ-028 Asserting rst immediately (asynchronously) sets every channel to: state IDLE, ctr 0, step and shadow DEF_STEP, clkout 1, tick 0.
REQ-029 During and immediately after reset: active = 0 and cfg_ready = 1.
REQ-030 Reset asserted mid-period or in PEND discards the shadow; no tick is emitted for the interrupted period.

Structure
REQ-031 Package clk_sched_pkg holds the channel state enum (IDLE, RUN, PEND) and the DEF_STEP and LEN default constants.
REQ-032 Per-channel logic is sub-module clk_sched_chan (FSM, ctr, step, shadow, clkout, tick); clk_sched instantiates NCH copies and decodes cfg_ch.
REQ-033 All outputs are registered, except cfg_ready, which is a combinational mux of the channel PEND flags.

Verification
REQ-034 Reset release, then cfg ch0 en=1 step=3 -> tick[0] at cycles 3,6,9 after accept; clkout[0] toggles 1->0->1 every 3 cycles; active=0001.
REQ-035 Ch1 running step=4, cfg step=2 at ctr=1 -> cfg_ready for ch1 low until the boundary, two more cycles at period 4, then period 2 with no glitch.
REQ-036 Ch2 running step=5, cfg en=0 on its boundary cycle -> no tick on the next edge; clkout[2]=1, active[2]=0.
REQ-037 Ch3 cfg step=0 -> tick[3] continuously high; clkout[3] toggles every cycle; other channels' timing unaffected.
REQ-038 rst pulsed asynchronously mid-PEND on ch0 -> outputs return to reset values without waiting for a clk edge; shadow is discarded; after release, ch0 is IDLE with cfg_ready=1.
REQ-039 Simultaneous traffic: back-to-back accepts to ch0..ch3 on consecutive cycles with steps 1,2,3,4 -> each channel's tick period matches its own step; cfg_ready stays high throughout.

Source files
------------

// File: rtl/clk_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_sched_pkg
// Description : Shared types and default constants for the clock scheduler:
//               per-channel state encoding plus the default counter width
//               and reset half-period.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_sched_pkg;

  // Per-channel divider state: stopped, running, or running with a queued step
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } chan_state_e;

  // Default counter / step width
  localparam int LEN_DEFAULT = 25;

  // Default half-period loaded at reset (0.5 s at 50 MHz)
  localparam int unsigned DEF_STEP_DEFAULT = 32'd25000000;

endpackage
`default_nettype wire

// File: rtl/clk_sched_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_sched_chan
// Description : One divider channel. Counts clk cycles up to a programmable
//               half-period, pulses tick and toggles clkout at each boundary.
//               A step change while running is held in a shadow register and
//               applied at the next boundary so no partial period appears.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_sched_chan
  import clk_sched_pkg::*;
#(
  parameter int          LEN      = LEN_DEFAULT,
  parameter int unsigned DEF_STEP = DEF_STEP_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,   // accepted command addressed to this channel
  input  logic           cmd_en,
  input  logic [LEN-1:0] cmd_step,
  output logic           tick,
  output logic           clkout,
  output logic           active,
  output logic           pend
);

  localparam logic [LEN-1:0] RST_STEP = LEN'(DEF_STEP);
  localparam logic [LEN-1:0] ONE      = LEN'(1);

  chan_state_e    state_q, state_d;
  logic [LEN-1:0] ctr_q, ctr_d;
  logic [LEN-1:0] step_q, step_d;
  logic [LEN-1:0] shadow_q, shadow_d;
  logic           clkout_q, clkout_d;
  logic           tick_q, tick_d;
  logic           active_q;
  logic [LEN-1:0] req_step;
  logic           boundary;

  // A zero step means "as fast as possible", i.e. a half-period of one cycle.
  // Because loaded steps are never zero, step_q - 1 never wraps.
  assign req_step = (cmd_step == '0) ? ONE : cmd_step;
  assign boundary = (ctr_q == (step_q - ONE));

  // State and datapath registers; reset is asynchronous and drops any shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ctr_q    <= '0;
      step_q   <= RST_STEP;
      shadow_q <= RST_STEP;
      clkout_q <= 1'b1;
      tick_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      step_q   <= step_d;
      shadow_q <= shadow_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
      active_q <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic: command handling, counting and boundary actions
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    step_d   = step_q;
    shadow_d = shadow_q;
    clkout_d = clkout_q;
    tick_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ctr_d    = '0;
        clkout_d = 1'b1;
        if (cmd_valid && cmd_en) begin
          state_d = ST_RUN;
          step_d  = req_step;
        end
      end

      ST_RUN: begin
        if (cmd_valid && !cmd_en) begin
          // Stop: the boundary that may be due this cycle is not emitted
          state_d  = ST_IDLE;
          ctr_d    = '0;
          clkout_d = 1'b1;
        end else begin
          if (boundary) begin
            ctr_d    = '0;
            tick_d   = 1'b1;
            clkout_d = !clkout_q;
          end else begin
            ctr_d = ctr_q + ONE;
          end
          // New step waits for the boundary after the current period
          if (cmd_valid) begin
            state_d  = ST_PEND;
            shadow_d = req_step;
          end
        end
      end

      ST_PEND: begin
        if (boundary) begin
          ctr_d    = '0;
          tick_d   = 1'b1;
          clkout_d = !clkout_q;
          step_d   = shadow_q;
          state_d  = ST_RUN;
        end else begin
          ctr_d = ctr_q + ONE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        ctr_d    = '0;
        clkout_d = 1'b1;
      end
    endcase
  end

  assign tick   = tick_q;
  assign clkout = clkout_q;
  assign active = active_q;
  assign pend   = (state_q == ST_PEND);

endmodule
`default_nettype wire

// File: rtl/clk_sched.sv
`default_nettype none
// ============================================================================
// Module      : clk_sched
// Description : Bank of NCH independent programmable clock dividers sharing a
//               single valid/ready configuration port. A channel with a step
//               change still pending back-pressures commands addressed to it.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_sched
  import clk_sched_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter int          LEN      = LEN_DEFAULT,
  parameter int unsigned DEF_STEP = DEF_STEP_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic                    cfg_en,
  input  logic [LEN-1:0]          cfg_step,
  output logic [NCH-1:0]          tick,
  output logic [NCH-1:0]          clkout,
  output logic [NCH-1:0]          active
);

  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0] sel;
  logic [NCH-1:0] pend;
  logic           accept;

  // An index that matches no channel selects nothing, so it is accepted and dropped
  assign cfg_ready = ~|(sel & pend);
  assign accept    = cfg_valid && cfg_ready;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_chan
      assign sel[i] = (cfg_ch == CHW'(i));

      clk_sched_chan #(
        .LEN      (LEN),
        .DEF_STEP (DEF_STEP)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (accept && sel[i]),
        .cmd_en    (cfg_en),
        .cmd_step  (cfg_step),
        .tick      (tick[i]),
        .clkout    (clkout[i]),
        .active    (active[i]),
        .pend      (pend[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_sched
// Description : Self-checking bench for clk_sched. A deadline-based reference
//               model (next boundary edge number per channel) is compared with
//               the DUT every cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_sched;

  localparam int NCH = 5;
  localparam int LEN = 8;
  localparam int CHW = 3;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_en    = 1'b0;
  logic [CHW-1:0] cfg_ch    = '0;
  logic [LEN-1:0] cfg_step  = '0;
  logic           cfg_ready;
  logic [NCH-1:0] tick, clkout, active;

  int vectors     = 0;
  int miscompares = 0;

  clk_sched #(.NCH(NCH), .LEN(LEN), .DEF_STEP(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_en    (cfg_en),
    .cfg_step  (cfg_step),
    .tick      (tick),
    .clkout    (clkout),
    .active    (active)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_run  [NCH];
  bit m_pend [NCH];
  bit m_clk  [NCH];
  bit m_tick [NCH];
  int m_per  [NCH];
  int m_sh   [NCH];
  int m_nb   [NCH];   // edge number of the next half-period boundary
  int n_edge;

  function automatic int eff(input logic [LEN-1:0] s);
    return (s == '0) ? 1 : int'(s);
  endfunction

  function automatic bit m_ready(input logic [CHW-1:0] ch);
    if (int'(ch) >= NCH) return 1'b1;
    return !m_pend[int'(ch)];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 1'b0; m_pend[i] = 1'b0; m_clk[i] = 1'b1; m_tick[i] = 1'b0;
      m_per[i] = 0; m_sh[i] = 0; m_nb[i] = 0;
    end
  endtask

  task automatic m_edge();
    bit acc;
    int ch;
    n_edge++;
    acc = cfg_valid && m_ready(cfg_ch);
    ch  = int'(cfg_ch);
    for (int i = 0; i < NCH; i++) begin
      bit hit;
      hit = acc && (ch == i);
      m_tick[i] = 1'b0;
      if (!m_run[i]) begin
        if (hit && cfg_en) begin
          m_run[i] = 1'b1;
          m_per[i] = eff(cfg_step);
          m_nb[i]  = n_edge + m_per[i];
        end
      end else if (hit && !cfg_en) begin
        m_run[i] = 1'b0; m_pend[i] = 1'b0; m_clk[i] = 1'b1;
      end else begin
        if (n_edge == m_nb[i]) begin
          m_tick[i] = 1'b1;
          m_clk[i]  = !m_clk[i];
          if (m_pend[i]) begin
            m_per[i]  = m_sh[i];
            m_pend[i] = 1'b0;
          end
          m_nb[i] = n_edge + m_per[i];
        end
        if (hit) begin
          m_pend[i] = 1'b1;
          m_sh[i]   = eff(cfg_step);
        end
      end
    end
  endtask

  initial begin
    n_edge = 0;
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_edge();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      begin
        logic [NCH-1:0] et, ec, ea;
        for (int i = 0; i < NCH; i++) begin
          et[i] = m_tick[i]; ec[i] = m_clk[i]; ea[i] = m_run[i];
        end
        chk("model_tick",   32'(tick),      32'(et));
        chk("model_clkout", 32'(clkout),    32'(ec));
        chk("model_active", 32'(active),    32'(ea));
        chk("model_ready",  32'(cfg_ready), 32'(m_ready(cfg_ch)));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmd(input int ch, input bit en, input int st);
    cfg_ch = CHW'(ch); cfg_en = en; cfg_step = LEN'(st); cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_tick"},   32'(tick),      32'(0));
    chk({nm, "_clkout"}, 32'(clkout),    32'(5'b11111));
    chk({nm, "_active"}, 32'(active),    32'(0));
    chk({nm, "_ready"},  32'(cfg_ready), 32'(1));
  endtask

  initial begin
    logic [9:0] th, tc;
    logic [7:0] rh;

    // Reset and release
    cyc(2);
    chk_reset_outputs("in_reset");
    rst = 1'b0;
    cyc(1);
    chk_reset_outputs("after_reset");

    // ch0 step 3: ticks at edges 3,6,9 after accept
    cmd(0, 1'b1, 3);
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      th[k-1] = tick[0]; tc[k-1] = clkout[0];
    end
    chk("ch0_tick_pattern",   32'(th), 32'(10'b0100100100));
    chk("ch0_clkout_pattern", 32'(tc), 32'(10'b0011100011));
    chk("ch0_active",         32'(active), 32'(5'b00001));
    cmd(0, 1'b0, 0);

    // ch1 step 4, change to 2 while ctr=1
    cmd(1, 1'b1, 4);
    cyc(1);
    cmd(1, 1'b1, 2);
    chk("ch1_ready_pend", 32'(cfg_ready), 32'(0));
    for (int k = 3; k <= 10; k++) begin
      cyc(1);
      th[k-3] = tick[1]; tc[k-3] = clkout[1]; rh[k-3] = cfg_ready;
    end
    chk("ch1_tick_pattern",   32'(th[7:0]), 32'(8'b10101010));
    chk("ch1_clkout_pattern", 32'(tc[7:0]), 32'(8'b10011001));
    chk("ch1_ready_pattern",  32'(rh),      32'(8'b11111110));
    cmd(1, 1'b0, 0);

    // ch2 step 5, stop on its boundary cycle
    cmd(2, 1'b1, 5);
    cyc(4);
    cmd(2, 1'b0, 0);
    chk("ch2_stop_tick",   32'(tick[2]),   32'(0));
    chk("ch2_stop_clkout", 32'(clkout[2]), 32'(1));
    chk("ch2_stop_active", 32'(active[2]), 32'(0));

    // ch3 step 0 alongside ch4 step 2
    cmd(4, 1'b1, 2);
    cmd(3, 1'b1, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      th[k-1] = tick[3]; tc[k-1] = clkout[3];
    end
    chk("ch3_tick_high",   32'(th[5:0]), 32'(6'b111111));
    chk("ch3_clkout_fast", 32'(tc[5:0]), 32'(6'b101010));
    cmd(3, 1'b0, 0);
    cmd(4, 1'b0, 0);

    // Asynchronous reset while ch0 has a step change pending
    cmd(0, 1'b1, 3);
    cyc(1);
    cmd(0, 1'b1, 6);
    chk("ch0_pend_ready",  32'(cfg_ready), 32'(0));
    chk("ch0_pend_active", 32'(active),    32'(5'b00001));
    #3 rst = 1'b1;
    #1 chk_reset_outputs("async_reset");
    #2 rst = 1'b0;
    cyc(4);
    chk_reset_outputs("post_async");
    cmd(0, 1'b1, 2);
    cyc(6);
    cmd(0, 1'b0, 0);

    // Back-to-back accepts to ch0..ch3 with steps 1..4
    for (int i = 0; i < 4; i++) begin
      cfg_ch = CHW'(i); cfg_en = 1'b1; cfg_step = LEN'(i + 1); cfg_valid = 1'b1;
      #1 chk("b2b_ready", 32'(cfg_ready), 32'(1));
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    cyc(12);
    chk("b2b_ch0_tick", 32'(tick[0]), 32'(1));
    chk("b2b_active",   32'(active),  32'(5'b01111));
    for (int i = 0; i < 4; i++) cmd(i, 1'b0, 0);

    // Randomized traffic, including out-of-range channels and reset pulses
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        cfg_valid = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        cfg_valid = ($urandom_range(0, 1) == 1);
        cfg_ch    = CHW'($urandom_range(0, 7));
        cfg_en    = ($urandom_range(0, 4) != 0);
        cfg_step  = ($urandom_range(0, 9) == 0) ? LEN'($urandom_range(0, 40))
                                                : LEN'($urandom_range(0, 6));
        @(posedge clk); #1;
      end
    end
    cfg_valid = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
